// File: rtl/wfq_req_sched.sv
// wfq_req_sched: round-robin front end that divides pkt_len by class weight and issues tagged requests to the WFQ engine.
// Define WFQ_REQ_SCHED_STATS_EN to add per-port grant counters and a hazard-stall counter.
module wfq_req_sched #(
    parameter int NUM_PORTS    = 4,
    parameter int CLASS_WIDTH  = 5,
    parameter int WEIGHT_WIDTH = 16,
    parameter int PKT_WIDTH    = 16,
    parameter int RESULT_WIDTH = 32,
    parameter int ENGINE_LAT   = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              in_valid,
    output logic [NUM_PORTS-1:0]              in_ready,
    input  logic [NUM_PORTS*CLASS_WIDTH-1:0]  in_class_id,
    input  logic [NUM_PORTS*PKT_WIDTH-1:0]    in_pkt_len,
    input  logic                              cfg_wr_en,
    input  logic [CLASS_WIDTH-1:0]            cfg_class_id,
    input  logic [WEIGHT_WIDTH-1:0]           cfg_weight,
    output logic                              eng_req_valid,
    output logic [CLASS_WIDTH-1:0]            eng_class_id,
    output logic [WEIGHT_WIDTH-1:0]           eng_div_quotient,
    output logic [WEIGHT_WIDTH-1:0]           eng_div_remain,
    input  logic                              eng_resp_valid,
    input  logic [RESULT_WIDTH-1:0]           eng_resp_data,
    output logic                              out_valid,
    output logic [RESULT_WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_PORTS)-1:0]      out_port,
    output logic                              err_orphan
`ifdef WFQ_REQ_SCHED_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]           stat_grants,
    output logic [31:0]                       stat_stall
`endif
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(PKT_WIDTH + 1);
    localparam int NC = 2 ** CLASS_WIDTH;
    localparam int QW = PKT_WIDTH > WEIGHT_WIDTH ? PKT_WIDTH : WEIGHT_WIDTH;
    localparam int TW = ENGINE_LAT * PW;
    typedef enum logic [1:0] {IDLE, DIV, ISSUE} state_t;
    state_t                   state_q, state_d;
    logic [PW-1:0]            rr_ptr_q, rr_ptr_d, port_q, port_d, grant, idx;
    logic                     found, accept, stall, in_div, last, zero_w, ge, sat, tag_hit;
    logic [CLASS_WIDTH-1:0]   class_q, class_d, sel_class;
    logic [PKT_WIDTH-1:0]     quo_q, quo_d, sel_len, step_quo;
    logic [WEIGHT_WIDTH-1:0]  weight_q, weight_d, rem_q, rem_d, sel_weight, step_rem;
    logic [WEIGHT_WIDTH-1:0]  eng_quo_q, eng_quo_d, eng_rem_q, eng_rem_d;
    logic [WEIGHT_WIDTH:0]    trial;
    logic [QW-1:0]            quo_ext;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [WEIGHT_WIDTH-1:0]  wtab_q [NC];
    logic [WEIGHT_WIDTH-1:0]  wtab_d [NC];
    logic [1:0]               hv_q, hv_d;
    logic [2*CLASS_WIDTH-1:0] hc_q, hc_d;
    logic [ENGINE_LAT-1:0]    tag_v_q, tag_v_d;
    logic [TW-1:0]            tag_p_q, tag_p_d;
    logic                     out_valid_q, out_valid_d, err_orphan_q, err_orphan_d;
    logic [RESULT_WIDTH-1:0]  out_data_q, out_data_d;
    logic [PW-1:0]            out_port_q, out_port_d;
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = rr_ptr_q + PW'(i);
            if (in_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end
    assign sel_class  = in_class_id[grant*CLASS_WIDTH +: CLASS_WIDTH];
    assign sel_len    = in_pkt_len[grant*PKT_WIDTH +: PKT_WIDTH];
    assign sel_weight = (cfg_wr_en && cfg_class_id == sel_class) ? cfg_weight : wtab_q[sel_class];
    assign zero_w     = sel_weight == '0;
    // Same-class issues within the last two cycles would collide inside the engine.
    assign stall   = (hv_q[0] && hc_q[CLASS_WIDTH-1:0] == class_q) || (hv_q[1] && hc_q[2*CLASS_WIDTH-1:CLASS_WIDTH] == class_q);
    assign in_div  = state_q == DIV;
    assign last    = in_div && cnt_q == CW'(1);
    assign trial   = {rem_q, quo_q[PKT_WIDTH-1]};
    assign ge      = trial >= {1'b0, weight_q};
    assign step_rem = ge ? WEIGHT_WIDTH'(trial - {1'b0, weight_q}) : trial[WEIGHT_WIDTH-1:0];
    assign step_quo = {quo_q[PKT_WIDTH-2:0], ge};
    assign quo_ext  = QW'(step_quo);
    assign sat      = |(quo_ext >> WEIGHT_WIDTH);
    assign tag_hit  = tag_v_q[ENGINE_LAT-1];
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (zero_w ? ISSUE : DIV) : IDLE;
            DIV:     state_d = last ? ISSUE : DIV;
            ISSUE:   state_d = stall ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        in_ready      = (state_q == IDLE && found && !rst) ? (NUM_PORTS'(1) << grant) : '0;
        eng_req_valid = state_q == ISSUE && !stall && !rst;
    end
    assign accept = |in_ready;
    always_comb begin
        rr_ptr_d  = accept ? grant + PW'(1) : rr_ptr_q;
        port_d    = accept ? grant : port_q;
        class_d   = accept ? sel_class : class_q;
        weight_d  = accept ? sel_weight : weight_q;
        quo_d     = accept ? sel_len : (in_div ? step_quo : quo_q);
        rem_d     = accept ? '0 : (in_div ? step_rem : rem_q);
        cnt_d     = accept ? CW'(PKT_WIDTH) : (in_div ? cnt_q - CW'(1) : cnt_q);
        eng_quo_d = (accept && zero_w) ? '1 : (last ? (sat ? '1 : quo_ext[WEIGHT_WIDTH-1:0]) : eng_quo_q);
        eng_rem_d = (accept && zero_w) ? '0 : (last ? step_rem : eng_rem_q);
        wtab_d    = wtab_q;
        if (cfg_wr_en) wtab_d[cfg_class_id] = cfg_weight;
        hv_d         = {hv_q[0], eng_req_valid};
        hc_d         = {hc_q[CLASS_WIDTH-1:0], class_q};
        tag_v_d      = ENGINE_LAT'({tag_v_q, eng_req_valid});
        tag_p_d      = TW'({tag_p_q, port_q});
        out_valid_d  = eng_resp_valid && tag_hit;
        out_data_d   = out_valid_d ? eng_resp_data : out_data_q;
        out_port_d   = out_valid_d ? tag_p_q[TW-1 -: PW] : out_port_q;
        err_orphan_d = err_orphan_q || (eng_resp_valid && !tag_hit);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            port_q       <= '0;
            class_q      <= '0;
            weight_q     <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            eng_quo_q    <= '0;
            eng_rem_q    <= '0;
            for (int i = 0; i < NC; i++) wtab_q[i] <= WEIGHT_WIDTH'(1);
            hv_q         <= '0;
            hc_q         <= '0;
            tag_v_q      <= '0;
            tag_p_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_port_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            port_q       <= port_d;
            class_q      <= class_d;
            weight_q     <= weight_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            eng_quo_q    <= eng_quo_d;
            eng_rem_q    <= eng_rem_d;
            wtab_q       <= wtab_d;
            hv_q         <= hv_d;
            hc_q         <= hc_d;
            tag_v_q      <= tag_v_d;
            tag_p_q      <= tag_p_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_port_q   <= out_port_d;
            err_orphan_q <= err_orphan_d;
        end
    end
    assign eng_class_id     = class_q;
    assign eng_div_quotient = eng_quo_q;
    assign eng_div_remain   = eng_rem_q;
    assign out_valid        = out_valid_q;
    assign out_data         = out_data_q;
    assign out_port         = out_port_q;
    assign err_orphan       = err_orphan_q;
`ifdef WFQ_REQ_SCHED_STATS_EN
    logic [NUM_PORTS*32-1:0] stat_grants_q, stat_grants_d;
    logic [31:0]             stat_stall_q, stat_stall_d;
    always_comb begin
        stat_grants_d = stat_grants_q;
        for (int p = 0; p < NUM_PORTS; p++) stat_grants_d[p*32 +: 32] = stat_grants_q[p*32 +: 32] + 32'(in_ready[p]);
        stat_stall_d = stat_stall_q + 32'(state_q == ISSUE && stall);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_grants_q <= stat_grants_d;
            stat_stall_q  <= stat_stall_d;
        end
    end
    assign stat_grants = stat_grants_q;
    assign stat_stall  = stat_stall_q;
`endif
endmodule

// File: tb/tb_wfq_req_sched.sv
// tb_wfq_req_sched: vector table plus corner sequences, scoreboarded against a fixed-latency engine model.
module tb_wfq_req_sched;
    localparam int NP = 4, CWID = 5, WW = 16, PKW = 16, RW = 32, L = 3;
    logic              clk = 1'b0, rst = 1'b1;
    logic [NP-1:0]     in_valid = '0, in_ready;
    logic [NP*CWID-1:0] in_class_id = '0;
    logic [NP*PKW-1:0] in_pkt_len = '0;
    logic              cfg_wr_en = 1'b0;
    logic [CWID-1:0]   cfg_class_id = '0;
    logic [WW-1:0]     cfg_weight = '0;
    logic              eng_req_valid, eng_resp_valid, out_valid, err_orphan;
    logic [CWID-1:0]   eng_class_id;
    logic [WW-1:0]     eng_div_quotient, eng_div_remain;
    logic [RW-1:0]     eng_resp_data, out_data;
    logic [1:0]        out_port;
`ifdef WFQ_REQ_SCHED_STATS_EN
    logic [NP*32-1:0]  stat_grants;
    logic [31:0]       stat_stall;
`endif
    wfq_req_sched dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_class_id(in_class_id), .in_pkt_len(in_pkt_len),
        .cfg_wr_en(cfg_wr_en), .cfg_class_id(cfg_class_id), .cfg_weight(cfg_weight),
        .eng_req_valid(eng_req_valid), .eng_class_id(eng_class_id),
        .eng_div_quotient(eng_div_quotient), .eng_div_remain(eng_div_remain),
        .eng_resp_valid(eng_resp_valid), .eng_resp_data(eng_resp_data),
        .out_valid(out_valid), .out_data(out_data), .out_port(out_port), .err_orphan(err_orphan)
`ifdef WFQ_REQ_SCHED_STATS_EN
        , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0, cyc = 0;
    int last_iss = 0, prev_iss = 0;
    always @(posedge clk) cyc <= cyc + 1;
    // Engine stand-in: fixed latency, result is {quotient, remainder} of the request.
    logic [L-1:0] pv = '0;
    logic [RW-1:0] pd [L];
    logic inj = 1'b0;
    always @(posedge clk) begin
        pv <= {pv[L-2:0], eng_req_valid};
        pd[0] <= {eng_div_quotient, eng_div_remain};
        for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end
    assign eng_resp_valid = pv[L-1] | inj;
    assign eng_resp_data  = pd[L-1];
    typedef struct {int port; int cls; int quo; int rem; int due;} exp_t;
    exp_t req_q[$], out_q[$];
    exp_t me;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        if (eng_req_valid === 1'b1) begin
            if (req_q.size() == 0) check("unexpected_issue", 1, 0);
            else begin
                me = req_q.pop_front();
                check("issue_class", 64'(eng_class_id), 64'(me.cls));
                check("issue_quo", 64'(eng_div_quotient), 64'(me.quo));
                check("issue_rem", 64'(eng_div_remain), 64'(me.rem));
                check("issue_cycle", 64'(cyc), 64'(me.due));
                prev_iss = last_iss;
                last_iss = cyc;
                me.due = cyc + L + 1;
                out_q.push_back(me);
            end
        end
        if (out_valid === 1'b1) begin
            if (out_q.size() == 0) check("unexpected_out", 1, 0);
            else begin
                me = out_q.pop_front();
                check("out_port", 64'(out_port), 64'(me.port));
                check("out_data", 64'(out_data), (64'(me.quo) << 16) | 64'(me.rem));
                check("out_cycle", 64'(cyc), 64'(me.due));
            end
        end
    end
    task automatic push_exp(input int port, input int cls, input int quo, input int rem, input int lat);
        exp_t e;
        e = '{port, cls, quo, rem, cyc + lat};
        req_q.push_back(e);
    endtask
    task automatic set_port(input int port, input int cls, input int len);
        in_class_id[port*CWID +: CWID] = CWID'(cls);
        in_pkt_len[port*PKW +: PKW] = PKW'(len);
    endtask
    task automatic cfg_write(input int cls, input int w);
        @(posedge clk); #1;
        cfg_wr_en = 1'b1; cfg_class_id = CWID'(cls); cfg_weight = WW'(w);
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
    endtask
    task automatic run_req(input int port, input int cls, input int len, input int quo, input int rem, input int lat);
        bit got = 0;
        @(posedge clk); #1;
        set_port(port, cls, len);
        in_valid = NP'(1) << port;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (in_ready != '0) begin
                check("ready_port", 64'(in_ready), 64'(NP'(1) << port));
                push_exp(port, cls, quo, rem, lat);
                got = 1;
            end
        end
        check("ready_seen", 64'(got), 1);
        @(posedge clk); #1;
        in_valid = '0;
    endtask
    task automatic drain();
        for (int i = 0; i < 300 && (req_q.size() + out_q.size()) != 0; i++) @(negedge clk);
        check("drain", 64'(req_q.size() + out_q.size()), 0);
    endtask
    task automatic check_reset_vals();
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_eng_req_valid", 64'(eng_req_valid), 0);
        check("rst_eng_class", 64'(eng_class_id), 0);
        check("rst_eng_quo", 64'(eng_div_quotient), 0);
        check("rst_eng_rem", 64'(eng_div_remain), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_data", 64'(out_data), 0);
        check("rst_out_port", 64'(out_port), 0);
        check("rst_err_orphan", 64'(err_orphan), 0);
    endtask
    typedef struct {int port; int cls; int cfg; int w; int len; int quo; int rem; int lat;} vec_t;
    vec_t vecs [8];
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int g, last_g, nissue;
        int rr_cls [4];
`ifdef WFQ_REQ_SCHED_STATS_EN
        logic [31:0] st0, gr0;
`endif
        vecs[0] = '{2, 5, 1, 3, 100, 33, 1, 17};
        vecs[1] = '{0, 1, 1, 7, 1000, 142, 6, 17};
        vecs[2] = '{3, 31, 1, 1, 65535, 65535, 0, 17};
        vecs[3] = '{1, 7, 1, 0, 500, 65535, 0, 1};
        vecs[4] = '{2, 2, 1, 65535, 65534, 0, 65534, 17};
        vecs[5] = '{1, 9, 1, 16, 0, 0, 0, 17};
        vecs[6] = '{0, 3, 1, 40000, 50000, 1, 10000, 17};
        vecs[7] = '{3, 12, 0, 0, 1234, 1234, 0, 17};
        rr_cls = '{7, 4, 1, 3};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        foreach (vecs[i]) begin
            if (vecs[i].cfg != 0) cfg_write(vecs[i].cls, vecs[i].w);
            run_req(vecs[i].port, vecs[i].cls, vecs[i].len, vecs[i].quo, vecs[i].rem, vecs[i].lat);
            drain();
        end
        // Config write coinciding with accept of the same class is bypassed; a write during DIV is not.
        @(posedge clk); #1;
        cfg_wr_en = 1'b1; cfg_class_id = 6; cfg_weight = 5;
        set_port(0, 6, 100);
        in_valid = 4'b0001;
        @(negedge clk);
        check("bypass_ready", 64'(in_ready), 1);
        push_exp(0, 6, 20, 0, 17);
        @(posedge clk); #1;
        in_valid = '0; cfg_weight = 9;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
        drain();
        run_req(1, 6, 100, 11, 1, 17);
        drain();
        // Back-to-back weight-0 requests of one class: second issue held off by the hazard stall.
        cfg_write(4, 0);
`ifdef WFQ_REQ_SCHED_STATS_EN
        st0 = stat_stall;
        gr0 = stat_grants[32 +: 32];
`endif
        @(posedge clk); #1;
        set_port(1, 4, 10);
        in_valid = 4'b0010;
        g = 0;
        for (int i = 0; i < 50 && g < 2; i++) begin
            @(negedge clk);
            if (in_ready != '0) begin
                check("b2b_ready", 64'(in_ready), 2);
                push_exp(1, 4, 65535, 0, g == 0 ? 1 : 2);
                g++;
            end
        end
        check("b2b_grants", 64'(g), 2);
        @(posedge clk); #1;
        in_valid = '0;
        drain();
        check("b2b_gap", 64'(last_iss - prev_iss), 3);
`ifdef WFQ_REQ_SCHED_STATS_EN
        check("stat_stall_inc", 64'(stat_stall - st0), 1);
        check("stat_grants_inc", 64'(stat_grants[32 +: 32] - gr0), 2);
`endif
        // Orphan response: dropped, sticky error until reset.
        @(posedge clk); #1 inj = 1'b1;
        @(posedge clk); #1 inj = 1'b0;
        @(negedge clk);
        check("orphan_out_valid", 64'(out_valid), 0);
        check("orphan_err", 64'(err_orphan), 1);
        repeat (5) @(negedge clk);
        check("orphan_err_sticky", 64'(err_orphan), 1);
        // Reset in the middle of a divide: nothing issues afterwards.
        @(posedge clk); #1;
        set_port(2, 5, 100);
        in_valid = 4'b0100;
        @(negedge clk);
        check("abort_ready", 64'(in_ready), 4);
        @(posedge clk); #1;
        in_valid = '0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        nissue = 0;
        repeat (30) begin
            @(negedge clk);
            if (eng_req_valid === 1'b1) nissue++;
        end
        check("abort_no_issue", 64'(nissue), 0);
        // All ports requesting: rotation 0,1,2,3,0 with reset weights of 1.
        @(posedge clk); #1;
        for (int p = 0; p < NP; p++) set_port(p, rr_cls[p], 100 + p * 11);
        in_valid = 4'hF;
        g = 0;
        last_g = 0;
        for (int i = 0; i < 200 && g < 5; i++) begin
            @(negedge clk);
            if (in_ready != '0) begin
                check("rr_order", 64'(in_ready), 64'(NP'(1) << (g % 4)));
                if (g > 0) check("rr_spacing", 64'(cyc - last_g), 18);
                push_exp(g % 4, rr_cls[g % 4], 100 + (g % 4) * 11, 0, 17);
                last_g = cyc;
                g++;
            end
        end
        check("rr_grants", 64'(g), 5);
        @(posedge clk); #1;
        in_valid = '0;
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
